uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the `uart` receiver. It detects each byte the receiver holds (`rx_empty` low), writes `rx_data` into a first-word-fall-through FIFO, and drives the receiver's `uld_rx_data` unload handshake. It presents the buffered bytes to the consumer logic on the system clock. Overrun is flagged instead of stalling the UART.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in bytes; power of two, minimum 2.
- `AW`, 4: pointer width, log2(DEPTH).

Ports:
- `clk` in 1: system clock (50 MHz); the only clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte from `uart`; stable while `rx_empty` is low.
- `rx_empty` in 1: from `uart`; low means a byte is held.
- `uld_rx_data` out 1: unload request level to `uart`.
- `rd_en` in 1: consumer pop strobe, one byte per cycle.
- `rd_data` out 8: head of FIFO; valid when `fifo_empty` is 0.
- `fifo_empty` out 1: FIFO holds 0 bytes.
- `fifo_full` out 1: FIFO holds DEPTH bytes.
- `count` out AW+1: bytes stored, 0..DEPTH.
- `overrun` out 1: sticky; set when a byte arrives while the FIFO is full.

## Operation
- The capture FSM has four states: IDLE, CAPTURE, ACK, WAIT_EMPTY.
  - IDLE: when `rxe_s` (the conditioned `rx_empty`) is 0, go to CAPTURE.
  - CAPTURE: one cycle. Write `rx_data` at `wr_ptr` if not full (or if full with `rd_en` in the same cycle). Otherwise drop the byte and set `overrun`. Go to ACK.
  - ACK: drive `uld_rx_data`=1; go to WAIT_EMPTY.
  - WAIT_EMPTY: hold `uld_rx_data`=1 until `rxe_s`=1, then drop it and go to IDLE.
- The level handshake exists because `uart` samples `uld_rx_data` only on its slow `rxclk` tick. A one-cycle pulse would be missed.
- FIFO behaviour:
  - Circular buffer with AW-bit `wr_ptr` and `rd_ptr`; both wrap DEPTH-1 to 0.
  - `count` is tracked explicitly.
  - `rd_data` = `mem[rd_ptr]`, asynchronous read of a registered array.
- Read rules:
  - `rd_en` while empty is ignored; no pointer or count change.
  - Simultaneous write and read: both pointers advance and `count` is unchanged. This also applies at full, so no overrun.
- `overrun` stays set until `reset`. The dropped byte is still unloaded, so the receiver never stalls.
- Reset mid-handshake: the FSM goes to IDLE and `uld_rx_data` goes to 0. A byte still held by `uart` is captured again after reset.

## Timing
- Reset values:
  - `uld_rx_data`=0, `fifo_empty`=1, `fifo_full`=0, `count`=0, `overrun`=0.
  - Pointers = 0; `rd_data` = `mem[0]` (don't-care while empty).
- Capture latency:
  - `rxe_s` low in cycle N puts the FSM in CAPTURE at N+1.
  - The write is visible at N+2: `fifo_empty` falls, `count` increments, and `rd_data` shows the byte.
  - `uld_rx_data` rises at N+2 (ACK state registered).
- Pop: `rd_en` sampled high at edge E. `rd_ptr` and `count` update after E, and the next byte appears on `rd_data` in the same cycle.
- Flags and `count` are registered, never combinational from `rd_en`.
- Sustained throughput: 1 byte per UART frame. FIFO side: 1 write and 1 read per cycle.

## Configuration
- `UART_RX_FIFO_SYNC_EN` defined: `rx_empty` passes through a 2-flop synchronizer to form `rxe_s`. This adds 2 cycles to capture latency (first write visible at N+4 from raw `rx_empty` fall). Use it when `uart` runs on a derived clock.
- Not defined: `rxe_s` = `rx_empty` directly. Capture latency is as in Timing.
- `rx_data` is never synchronized. It is stable by protocol while `rx_empty` is low.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding: IDLE=0, CAPTURE=1, ACK=2, WAIT_EMPTY=3.
  - Byte width constant, 8.
  - Default FIFO depth constant, 16.
- Natural sub-module: `sync_fifo`, a generic FIFO (storage, pointers, count, flags). `uart_rx_fifo` keeps the capture FSM, the optional synchronizer and the overrun logic.

## Test plan
- Single byte: model `uart` drops `rx_empty` with `rx_data`=8'hA5.
  - Required: exactly one write; `rd_data`=8'hA5, `count`=1, `uld_rx_data` high until `rx_empty` rises.
  - Then `rd_en` for 1 cycle gives `fifo_empty`=1, `count`=0.
- Fill: send 16 bytes 8'h00..8'h0F with no reads.
  - Required: `fifo_full`=1, `count`=16.
  - 17th byte 8'hFF: dropped, `overrun`=1, `uld_rx_data` still completes the handshake.
  - Reads then return 8'h00..8'h0F in order.
- Wrap: repeat write 3 / read 3 for 40 bytes.
  - Required: data in order, no flag glitches, `count` never exceeds 3.
- Full with simultaneous pop: FIFO full, byte 8'h5A arrives in the same cycle as `rd_en`.
  - Required: `overrun`=0, `count` stays 16, and 8'h5A becomes the last entry.
- Empty read and reset: `rd_en` while empty leaves all state unchanged. Assert `reset` while in WAIT_EMPTY.
  - Required: next cycle `uld_rx_data`=0, `count`=0, `overrun`=0.
- Slow-tick handshake: model `uart` samples `uld_rx_data` only every 325 cycles.
  - Required: every byte is captured once, with no duplicates.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side buffer: byte width,
// default FIFO depth and the capture FSM state encoding.
package uart_pkg;

    localparam int BYTE_W     = 8;
    localparam int FIFO_DEPTH = 16;

    // Capture FSM states; the encoding is fixed so debug probes can decode it.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CAPTURE    = 2'd1,
        ST_ACK        = 2'd2,
        ST_WAIT_EMPTY = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO.
// Storage is a registered array read asynchronously at the read pointer.
// The count and both flags are registered and never depend combinationally on
// the strobes. A write into a full FIFO is accepted only when a read happens
// in the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = 4,
    parameter int W     = BYTE_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    output logic [W-1:0]  o_rd_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] LP_DEPTH_M1 = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] LP_ONE      = (AW + 1)'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_empty;
    logic          r_full;

    logic          w_do_rd;
    logic          w_do_wr;

    // A pop on an empty FIFO is ignored. A push on a full FIFO needs a pop in
    // the same cycle.
    assign w_do_rd = i_rd_en & ~r_empty;
    assign w_do_wr = i_wr_en & (~r_full | w_do_rd);

    // Storage array: written at the write pointer, never cleared.
    // NOTE: the data array has no reset. The count and flags mark which
    // entries are valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, count and flags. All of them wrap and update together.
    // NOTE: every state register uses non-blocking assignments, so all
    // updates in this block see the values from the previous clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10: begin
                    r_count <= r_count + LP_ONE;
                    r_empty <= 1'b0;
                    r_full  <= (r_count == LP_DEPTH_M1);
                end
                2'b01: begin
                    r_count <= r_count - LP_ONE;
                    r_full  <= 1'b0;
                    r_empty <= (r_count == LP_ONE);
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = r_empty;
    assign o_full    = r_full;
    assign o_count   = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer downstream of the uart receiver.
// It captures each byte the receiver holds and buffers it in a FWFT FIFO.
// The receiver is unloaded with a level handshake, because the uart samples
// uld_rx_data only on its slow rxclk tick. A byte that arrives at a full FIFO
// is dropped and raises the sticky overrun flag, so the receiver never stalls.
// Build option: define UART_RX_FIFO_SYNC_EN to pass rx_empty through a
// 2-flop synchronizer. This adds 2 cycles of capture latency.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_empty,
    output logic              uld_rx_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [AW:0]       count,
    output logic              overrun
);

    rx_state_t r_state;
    logic      r_uld;
    logic      r_overrun;

    logic      w_rxe_s;
    logic      w_capture;
    logic      w_drop;

`ifdef UART_RX_FIFO_SYNC_EN
    logic r_rxe_meta;
    logic r_rxe_sync;

    // Two-flop synchronizer for rx_empty. Reset to 1 ("nothing held") so that
    // a reset never looks like an incoming byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxe_meta <= 1'b1;
            r_rxe_sync <= 1'b1;
        end else begin
            r_rxe_meta <= rx_empty;
            r_rxe_sync <= r_rxe_meta;
        end
    end

    assign w_rxe_s = r_rxe_sync;
`else
    assign w_rxe_s = rx_empty;
`endif

    // The write happens during the single CAPTURE cycle. rx_data is stable by
    // protocol while rx_empty is low, so it feeds the FIFO directly.
    assign w_capture = (r_state == ST_CAPTURE);
    assign w_drop    = w_capture & fifo_full & ~rd_en;

    // Capture FSM with a registered unload request. uld_rx_data rises when the
    // FSM enters ACK and holds until the receiver reports empty again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_uld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxe_s) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_ACK;
                    r_uld   <= 1'b1;
                end
                ST_ACK: begin
                    r_state <= ST_WAIT_EMPTY;
                    r_uld   <= 1'b1;
                end
                ST_WAIT_EMPTY: begin
                    if (w_rxe_s) begin
                        r_state <= ST_IDLE;
                        r_uld   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_uld   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag, set when a captured byte has to be dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_capture),
        .i_wr_data (rx_data),
        .i_rd_en   (rd_en),
        .o_rd_data (rd_data),
        .o_empty   (fifo_empty),
        .o_full    (fifo_full),
        .o_count   (count)
    );

    assign uld_rx_data = r_uld;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A behavioural uart model presents
// bytes and unloads them on its own tick. Each result is compared with a
// queue-based model of the buffer.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_SYNC_EN
    localparam int CAP_EDGES = 3;
`else
    localparam int CAP_EDGES = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       uld_rx_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       fifo_empty;
    logic       fifo_full;
    logic [4:0] count;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    bit         exp_ovr = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .uld_rx_data (uld_rx_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .count       (count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Buffer model: a byte that reaches the FIFO is kept if there is room,
    // otherwise it is lost and overrun is set.
    task automatic model_write(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"},   32'(count),      32'(exp_q.size()));
        check({tag, "_empty"},   32'(fifo_empty), 32'(exp_q.size() == 0));
        check({tag, "_full"},    32'(fifo_full),  32'(exp_q.size() == DEPTH));
        check({tag, "_overrun"}, 32'(overrun),    32'(exp_ovr));
        if (exp_q.size() > 0) check({tag, "_rd_data"}, 32'(rd_data), 32'(exp_q[0]));
    endtask

    // uart model: hold a byte with rx_empty low.
    task automatic present(input logic [7:0] b);
        rx_data  = b;
        rx_empty = 1'b0;
    endtask

    // uart model: sample uld_rx_data once every 'tick' cycles. Release the byte
    // when the request is seen. Then wait for the request to drop.
    task automatic unload(input int tick, input string tag);
        int  phase;
        int  n;
        bit  seen_hi;
        bit  dropped;
        bit  done;
        phase   = (tick > 1) ? int'($urandom_range(0, tick - 1)) : 0;
        n       = 0;
        seen_hi = 1'b0;
        dropped = 1'b0;
        done    = 1'b0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
            if (uld_rx_data) seen_hi = 1'b1;
            else if (seen_hi) dropped = 1'b1;
            if (((n + phase) % tick) == 0 && uld_rx_data) begin
                rx_empty = 1'b1;
                done     = 1'b1;
            end
        end
        check({tag, "_unloaded"}, 32'(done), 32'd1);
        check({tag, "_uld_held"}, 32'(dropped), 32'd0);
        n = 0;
        while (uld_rx_data && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_uld_release"}, 32'(uld_rx_data), 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input int tick, input string tag);
        present(b);
        model_write(b);
        unload(tick, tag);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            check({tag, "_data"}, 32'(rd_data), 32'(exp_q[0]));
            pop();
        end
        check_state({tag, "_drained"});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int         n;
        reset    = 1'b1;
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_uld", 32'(uld_rx_data), 32'd0);
        check_state("rst");

        // Single byte with the exact capture latency
        present(8'hA5);
        repeat (CAP_EDGES) @(negedge clk);
        check("lat_early_empty", 32'(fifo_empty), 32'd1);
        check("lat_early_uld", 32'(uld_rx_data), 32'd0);
        @(negedge clk);
        check("lat_empty", 32'(fifo_empty), 32'd0);
        check("lat_count", 32'(count), 32'd1);
        check("lat_rd_data", 32'(rd_data), 32'hA5);
        check("lat_uld", 32'(uld_rx_data), 32'd1);
        model_write(8'hA5);
        unload(1, "single");
        check_state("single_after");
        pop();
        check_state("single_pop");

        // Fill to full, then one byte too many
        for (int i = 0; i < DEPTH; i++) send(8'(i), 1, "fill");
        check_state("fill_full");
        send(8'hFF, 1, "ovr");
        check_state("ovr_state");
        drain("fill_drain");
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Wrap: groups of up to 3 writes then 3 reads, 40 random bytes
        do_reset();
        n = 0;
        while (n < 40) begin
            int grp;
            grp = (40 - n < 3) ? (40 - n) : 3;
            for (int k = 0; k < grp; k++) begin
                send(8'($urandom), 1, "wrap");
                check("wrap_count_le3", 32'(count <= 5'd3), 32'd1);
            end
            for (int k = 0; k < grp; k++) begin
                check("wrap_data", 32'(rd_data), 32'(exp_q[0]));
                pop();
                check_state("wrap_pop");
            end
            n += grp;
        end

        // Full with a simultaneous pop in the capture cycle
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1, "pfill");
        check_state("pfill_full");
        present(8'h5A);
        repeat (CAP_EDGES) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h5A);
        unload(1, "fullpop");
        check_state("fullpop_state");
        drain("fullpop_drain");

        // Pop while empty is ignored
        rd_en = 1'b1;
        repeat (2) @(negedge clk);
        rd_en = 1'b0;
        check_state("empty_rd");
        send(8'h3C, 1, "after_empty_rd");
        check_state("after_empty_rd_state");
        pop();

        // Reset in the middle of a handshake, with overrun set
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1, "rfill");
        b = 8'($urandom);
        present(b);
        exp_ovr = 1'b1;
        n = 0;
        while (!uld_rx_data && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("rmid_uld_before", 32'(uld_rx_data), 32'd1);
        check("rmid_ovr_before", 32'(overrun), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rmid_uld", 32'(uld_rx_data), 32'd0);
        check("rmid_count", 32'(count), 32'd0);
        check("rmid_overrun", 32'(overrun), 32'd0);
        check("rmid_empty", 32'(fifo_empty), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        model_write(b);  // byte still held by the uart is captured again
        unload(1, "recapture");
        check_state("recapture_state");
        drain("recapture_drain");

        // Slow-tick handshake: each byte must be captured exactly once
        for (int i = 0; i < 5; i++) send(8'($urandom), 325, "slow");
        check_state("slow_state");
        drain("slow_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
